// File: rtl/exec_stage_vp_if.sv
// rtl/exec_stage_vp_if.sv - issue and result handshake bundle for the vector execute stage
interface exec_stage_vp_if #(
    parameter int SCALAR_W = 21,
    parameter int LANES    = 8,
    parameter int LANE_W   = 24,
    parameter int OPC_W    = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [OPC_W-1:0]          exc;
    logic [SCALAR_W-1:0]       r1e;
    logic [SCALAR_W-1:0]       r2e;
    logic [SCALAR_W-1:0]       imm;
    logic [LANES*LANE_W-1:0]   r1v;
    logic [LANES*LANE_W-1:0]   r2v;
    logic                      out_valid;
    logic                      out_ready;
    logic [SCALAR_W-1:0]       res_e;
    logic [LANES*LANE_W-1:0]   res_v;
    logic                      res_is_vec;
    logic                      illegal;

    modport master (
        output in_valid, exc, r1e, r2e, imm, r1v, r2v, out_ready,
        input  in_ready, out_valid, res_e, res_v, res_is_vec, illegal
    );

    modport slave (
        input  in_valid, exc, r1e, r2e, imm, r1v, r2v, out_ready,
        output in_ready, out_valid, res_e, res_v, res_is_vec, illegal
    );
endinterface

// File: rtl/exec_stage_vp.sv
// rtl/exec_stage_vp.sv - scalar/vector execute stage with registered output and lane-serial multiply
module exec_stage_vp #(
    parameter int SCALAR_W = 21,
    parameter int LANES    = 8,
    parameter int LANE_W   = 24,
    parameter int OPC_W    = 5
) (
    input  logic           clk,
    input  logic           rst,
    exec_stage_vp_if.slave bus
);
    localparam int VW = LANES * LANE_W;
    localparam int CW = $clog2(LANES);
    localparam int BW = (LANE_W > SCALAR_W) ? LANE_W : SCALAR_W;

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_AND     = 4'd2;
    localparam logic [3:0] OP_OR      = 4'd3;
    localparam logic [3:0] OP_XOR     = 4'd4;
    localparam logic [3:0] OP_SLL     = 4'd5;
    localparam logic [3:0] OP_VS_ADD  = 4'd6;
    localparam logic [3:0] OP_VS_SUB  = 4'd7;
    localparam logic [3:0] OP_VV_ADD  = 4'd8;
    localparam logic [3:0] OP_VV_SUB  = 4'd9;
    localparam logic [3:0] OP_VV_ADDS = 4'd10;
    localparam logic [3:0] OP_VV_MUL  = 4'd11;

    typedef enum logic {IDLE, MUL} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [VW-1:0]       a_q, b_q, acc_q, acc_d;
    logic [LANE_W-1:0]   a_lane, b_lane;
    logic [2*LANE_W-1:0] prod;
    logic                cnt_last;

    logic                out_valid_q;
    logic [SCALAR_W-1:0] res_e_q;
    logic [VW-1:0]       res_v_q;
    logic                res_is_vec_q;
    logic                illegal_q;

    logic [OPC_W-1:0]    exc;
    logic [3:0]          op;
    logic [SCALAR_W-1:0] opb;
    logic [BW-1:0]       bext;
    logic [LANE_W-1:0]   bcast;
    logic                accept, out_fire, start_mul;

    logic [SCALAR_W-1:0] c_res_e;
    logic [VW-1:0]       c_res_v;
    logic                c_vec, c_ill;
    logic [LANE_W:0]     sat_sum;

    assign exc   = bus.exc;
    assign op    = exc[4:1];
    assign opb   = exc[0] ? bus.imm : bus.r2e;
    assign bext  = BW'(opb);
    assign bcast = bext[LANE_W-1:0];

    // Only accept when the output slot will be free after this edge; this is
    // what guarantees a finishing multiply never finds the output occupied.
    assign bus.in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign out_fire     = out_valid_q && bus.out_ready;
    assign start_mul    = accept && (op == OP_VV_MUL);

    assign bus.out_valid  = out_valid_q;
    assign bus.res_e      = res_e_q;
    assign bus.res_v      = res_v_q;
    assign bus.res_is_vec = res_is_vec_q;
    assign bus.illegal    = illegal_q;

    always_comb begin
        c_res_e = '0;
        c_res_v = '0;
        c_vec   = 1'b0;
        c_ill   = 1'b0;
        sat_sum = '0;
        case (op)
            OP_ADD: c_res_e = bus.r1e + opb;
            OP_SUB: c_res_e = bus.r1e - opb;
            OP_AND: c_res_e = bus.r1e & opb;
            OP_OR:  c_res_e = bus.r1e | opb;
            OP_XOR: c_res_e = bus.r1e ^ opb;
            OP_SLL: c_res_e = (32'(opb[4:0]) >= SCALAR_W) ? '0 : (bus.r1e << opb[4:0]);
            OP_VS_ADD: begin
                c_vec = 1'b1;
                for (int i = 0; i < LANES; i++)
                    c_res_v[i*LANE_W +: LANE_W] = bus.r1v[i*LANE_W +: LANE_W] + bcast;
            end
            OP_VS_SUB: begin
                c_vec = 1'b1;
                for (int i = 0; i < LANES; i++)
                    c_res_v[i*LANE_W +: LANE_W] = bus.r1v[i*LANE_W +: LANE_W] - bcast;
            end
            OP_VV_ADD: begin
                c_vec = 1'b1;
                for (int i = 0; i < LANES; i++)
                    c_res_v[i*LANE_W +: LANE_W] = bus.r1v[i*LANE_W +: LANE_W]
                                                + bus.r2v[i*LANE_W +: LANE_W];
            end
            OP_VV_SUB: begin
                c_vec = 1'b1;
                for (int i = 0; i < LANES; i++)
                    c_res_v[i*LANE_W +: LANE_W] = bus.r1v[i*LANE_W +: LANE_W]
                                                - bus.r2v[i*LANE_W +: LANE_W];
            end
            OP_VV_ADDS: begin
                c_vec = 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    sat_sum = {1'b0, bus.r1v[i*LANE_W +: LANE_W]}
                            + {1'b0, bus.r2v[i*LANE_W +: LANE_W]};
                    c_res_v[i*LANE_W +: LANE_W] = sat_sum[LANE_W] ? '1 : sat_sum[LANE_W-1:0];
                end
            end
            OP_VV_MUL: c_vec = 1'b1;
            default:   c_ill = 1'b1;
        endcase
    end

    assign a_lane   = a_q[int'(cnt_q)*LANE_W +: LANE_W];
    assign b_lane   = b_q[int'(cnt_q)*LANE_W +: LANE_W];
    assign prod     = {{LANE_W{1'b0}}, a_lane} * {{LANE_W{1'b0}}, b_lane};
    assign cnt_last = (cnt_q == CW'(LANES - 1));

    always_comb begin
        acc_d = acc_q;
        acc_d[int'(cnt_q)*LANE_W +: LANE_W] = prod[LANE_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_mul) state_d = MUL;
            MUL:     if (cnt_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            res_e_q      <= '0;
            res_v_q      <= '0;
            res_is_vec_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start_mul) begin
                        a_q   <= bus.r1v;
                        b_q   <= bus.r2v;
                        acc_q <= '0;
                        cnt_q <= '0;
                        if (out_fire) out_valid_q <= 1'b0;
                    end else if (accept) begin
                        res_e_q      <= c_res_e;
                        res_v_q      <= c_res_v;
                        res_is_vec_q <= c_vec;
                        illegal_q    <= c_ill;
                        out_valid_q  <= 1'b1;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    if (cnt_last) begin
                        res_v_q      <= acc_d;
                        res_e_q      <= '0;
                        res_is_vec_q <= 1'b1;
                        illegal_q    <= 1'b0;
                        out_valid_q  <= 1'b1;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/exec_stage_vp.md
Name: exec_stage_vp

Overview:
- Parametrised successor execute stage for the vector processor.
- Covers scalar ALU, vector-scalar (broadcast) and vector-vector operations on a configurable lane count and lane width.
- Adds a valid/ready handshake, a registered output and an iterative lane-serial vector multiply driven by a small FSM.
- Sits between decode/register read and writeback; back-pressure from writeback stalls the stage.

Parameters:
- SCALAR_W, 21: scalar operand/result width.
- LANES, 8: number of vector lanes (>=2).
- LANE_W, 24: bits per lane; vector width is LANES*LANE_W.
- OPC_W, 5: width of exc control field (fixed layout below; must be 5).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  stage can accept this cycle
- exc  in  OPC_W  bit0 = source select (1: imm, 0: r2e); bits[4:1] = op
- r1e  in  SCALAR_W  scalar operand A
- r2e  in  SCALAR_W  scalar operand B
- imm  in  SCALAR_W  immediate
- r1v  in  LANES*LANE_W  vector operand A, lane i at bits [i*LANE_W +: LANE_W]
- r2v  in  LANES*LANE_W  vector operand B
- out_valid  out  1  result registered
- out_ready  in  1  consumer accepts result
- res_e  out  SCALAR_W  scalar result
- res_v  out  LANES*LANE_W  vector result
- res_is_vec  out  1  1: res_v is meaningful; 0: res_e is meaningful
- illegal  out  1  op code unsupported

Behaviour:
- Operand B = exc[0] ? imm : r2e.
- Broadcast lane value: B zero-extended to LANE_W, or truncated to the low LANE_W bits if LANE_W < SCALAR_W.
- All arithmetic is modulo 2^width unless stated otherwise.

Op codes (exc[4:1]):
- 0 ADD: res_e = A + B.
- 1 SUB: res_e = A - B.
- 2 AND, 3 OR, 4 XOR: bitwise on scalars.
- 5 SLL: res_e = A << B[4:0]; shift >= SCALAR_W gives 0.
- 6 VS_ADD: each lane = r1v lane + broadcast. Vector op; r1v is used even though the operand is scalar-sourced.
- 7 VS_SUB: each lane = r1v lane - broadcast.
- 8 VV_ADD: lane-wise r1v + r2v.
- 9 VV_SUB: lane-wise r1v - r2v.
- 10 VV_ADDS: unsigned saturating lane add; on carry-out the lane becomes all-ones.
- 11 VV_MUL: lane-wise low LANE_W bits of the product; iterative.
- 12-15 illegal: res_e = 0, res_v = 0, illegal = 1, res_is_vec = 0; completes as a single-cycle op.

Handshake:
- Transfer in on the edge where in_valid && in_ready.
- Transfer out on the edge where out_valid && out_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready). This allows back-to-back single-cycle ops at full rate when out_ready = 1.
- Outputs hold stable while out_valid && !out_ready.
- out_valid clears on an accept edge unless a new result loads on the same edge.

FSM: IDLE, MUL.
- IDLE, single-cycle op accepted at edge N: result registered at edge N; out_valid = 1 from cycle N+1.
- IDLE, VV_MUL accepted at edge N: latch r1v and r2v, clear lane counter and result accumulator, go to MUL; in_ready = 0.
- MUL: one lane per edge, lane k written at edge N+1+k.
- After lane LANES-1 (edge N+LANES): load res_v, set res_is_vec = 1, set out_valid = 1, return to IDLE.
- MUL is entered only when the output register is free or being accepted. The output therefore cannot be blocked at completion.
- Lane counter width: $clog2(LANES); it never exceeds LANES-1.
- Input changes during MUL are ignored (operands are latched).

Reset (rst = 1 at an edge), including mid-MUL:
- state = IDLE, counter = 0.
- out_valid = 0, res_e = 0, res_v = 0, res_is_vec = 0, illegal = 0.
- An in-flight multiply is discarded.
- in_ready is 1 from the first cycle after reset deasserts.

Scalar ops set res_is_vec = 0 and leave res_v at 0. Vector ops set res_e = 0.

Test Plan:
- Reset, then ADD with exc = 5'b00001, r1e = 21'h1FFFFF, imm = 1, out_ready = 1 -> one cycle later out_valid = 1, res_e = 0 (wrap), res_is_vec = 0.
- VV_ADDS exc = {4'd10,1'b0}, lane0 = 24'hFFFFF0 + 24'h000020, lane1 = 5 + 7 -> res_v lane0 = 24'hFFFFFF, lane1 = 24'h00000C, other lanes = a+b.
- VS_ADD with exc[0] = 1, imm = 21'h100000, r1v lanes = i -> every lane i = 24'h100000 + i.
- VV_MUL with lanes a = i+2, b = 3 -> in_ready = 0 for 8 cycles; out_valid asserted exactly 8 cycles after acceptance; lane i = 3*(i+2).
- Hold out_ready = 0 after an ADD completes, keep in_valid = 1 with a SUB -> in_ready = 0 and outputs stable. Raise out_ready -> ADD accepted and SUB loaded on the same edge, out_valid stays 1.
- Assert rst at the 4th cycle of VV_MUL -> out_valid = 0, all results 0, in_ready = 1 next cycle. Then an op 13 -> illegal = 1, res_e = 0.
